// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, ALU_op,
// mux selects, FSM state encoding and the bundled control-output record.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;
  localparam logic [1:0] ALUOP_SLT  = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REG    = 2'b11;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_R    = 4'd2,
    S_WB_R      = 4'd3,
    S_MEM_ADDR  = 4'd4,
    S_MEM_READ  = 4'd5,
    S_WB_MEM    = 4'd6,
    S_MEM_WRITE = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_JAL       = 4'd10,
    S_EXEC_I    = 4'd11,
    S_WB_I      = 4'd12
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mdr_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } ctrl_t;

endpackage

// File: rtl/mc_output_decode.sv
// Combinational map from FSM state to every datapath strobe and select.
// jr only matters in EXEC_R; opcode only picks ALU_op in EXEC_I.
module mc_output_decode
  import mips_pkg::*;
(
  input  state_t      state_i,
  input  logic        jr_i,
  input  logic [5:0]  opcode_i,
  output ctrl_t       ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.ir_write  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.pc_src    = PCSRC_ALU;
        ctrl_o.pc_write  = 1'b1;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b = SRCB_IMM2;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_EXEC_R: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_B;
        ctrl_o.alu_op    = ALUOP_FUNC;
        if (jr_i) begin
          ctrl_o.pc_src   = PCSRC_REG;
          ctrl_o.pc_write = 1'b1;
        end
      end
      S_WB_R: begin
        ctrl_o.reg_dst    = REGDST_RD;
        ctrl_o.mem_to_reg = M2R_ALUOUT;
        ctrl_o.reg_write  = 1'b1;
      end
      S_MEM_ADDR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_MEM_READ: begin
        ctrl_o.iord      = 1'b1;
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.mdr_write = 1'b1;
      end
      S_WB_MEM: begin
        ctrl_o.reg_dst    = REGDST_RT;
        ctrl_o.mem_to_reg = M2R_MDR;
        ctrl_o.reg_write  = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl_o.iord      = 1'b1;
        ctrl_o.mem_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SRCB_B;
        ctrl_o.alu_op        = ALUOP_SUB;
        ctrl_o.pc_src        = PCSRC_ALUOUT;
        ctrl_o.pc_write_cond = 1'b1;
      end
      S_JUMP: begin
        ctrl_o.pc_src   = PCSRC_JUMP;
        ctrl_o.pc_write = 1'b1;
      end
      S_JAL: begin
        // PC already holds PC+4, so the link write and jump share this edge
        ctrl_o.reg_dst    = REGDST_RA;
        ctrl_o.mem_to_reg = M2R_PC;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.pc_src     = PCSRC_JUMP;
        ctrl_o.pc_write   = 1'b1;
      end
      S_EXEC_I: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = (opcode_i == OP_SLTI) ? ALUOP_SLT : ALUOP_ADD;
      end
      S_WB_I: begin
        ctrl_o.reg_dst    = REGDST_RT;
        ctrl_o.mem_to_reg = M2R_ALUOUT;
        ctrl_o.reg_write  = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle MIPS datapath: state register and
// next-state logic; output decoding lives in mc_output_decode.
module multicycle_controller
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       jr,
  output logic       PC_write,
  output logic       PC_write_cond,
  output logic       IorD,
  output logic       mem_read,
  output logic       mem_write,
  output logic       IR_write,
  output logic       MDR_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       reg_write,
  output logic       ALU_srcA,
  output logic [1:0] ALU_srcB,
  output logic [1:0] ALU_op,
  output logic [1:0] PC_src
);

  state_t state_q, state_d;
  ctrl_t  ctrl, ctrl_gated;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:       state_d = S_EXEC_R;
          OP_LW, OP_SW:   state_d = S_MEM_ADDR;
          OP_BEQ:         state_d = S_BRANCH;
          OP_J:           state_d = S_JUMP;
          OP_JAL:         state_d = S_JAL;
          OP_ADDI, OP_SLTI: state_d = S_EXEC_I;
          default:        state_d = S_FETCH;
        endcase
      end
      S_EXEC_R:    state_d = jr ? S_FETCH : S_WB_R;
      S_MEM_ADDR:  state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  state_d = S_WB_MEM;
      S_EXEC_I:    state_d = S_WB_I;
      default:     state_d = S_FETCH;
    endcase
  end

  mc_output_decode u_decode (
    .state_i  (state_q),
    .jr_i     (jr),
    .opcode_i (opcode),
    .ctrl_o   (ctrl)
  );

  // Reset parks the state in FETCH, whose strobes must stay quiet until release
  assign ctrl_gated = rst ? '0 : ctrl;

  // zero is consumed by the datapath's PC_write_cond qualification, not here
  logic unused_zero;
  assign unused_zero = zero;

  assign PC_write      = ctrl_gated.pc_write;
  assign PC_write_cond = ctrl_gated.pc_write_cond;
  assign IorD          = ctrl_gated.iord;
  assign mem_read      = ctrl_gated.mem_read;
  assign mem_write     = ctrl_gated.mem_write;
  assign IR_write      = ctrl_gated.ir_write;
  assign MDR_write     = ctrl_gated.mdr_write;
  assign reg_dst       = ctrl_gated.reg_dst;
  assign mem_to_reg    = ctrl_gated.mem_to_reg;
  assign reg_write     = ctrl_gated.reg_write;
  assign ALU_srcA      = ctrl_gated.alu_src_a;
  assign ALU_srcB      = ctrl_gated.alu_src_b;
  assign ALU_op        = ctrl_gated.alu_op;
  assign PC_src        = ctrl_gated.pc_src;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed instruction table, reset corner,
// then random instruction stream against a per-instruction cycle model.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       zero, jr;
  logic       PC_write, PC_write_cond, IorD, mem_read, mem_write, IR_write, MDR_write;
  logic [1:0] reg_dst, mem_to_reg, ALU_srcB, ALU_op, PC_src;
  logic       reg_write, ALU_srcA;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .jr(jr),
    .PC_write(PC_write), .PC_write_cond(PC_write_cond), .IorD(IorD),
    .mem_read(mem_read), .mem_write(mem_write), .IR_write(IR_write),
    .MDR_write(MDR_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .ALU_srcA(ALU_srcA), .ALU_srcB(ALU_srcB),
    .ALU_op(ALU_op), .PC_src(PC_src)
  );

  // field order: pcw pcwc iord mrd mwr irw mdrw rdst[2] m2r[2] rw srca srcb[2] aop[2] pcs[2]
  function automatic logic [18:0] mk(input logic pcw, pcwc, iord, mrd, mwr, irw, mdrw,
                                     input logic [1:0] rdst, m2r, input logic rw, srca,
                                     input logic [1:0] srcb, aop, pcs);
    return {pcw, pcwc, iord, mrd, mwr, irw, mdrw, rdst, m2r, rw, srca, srcb, aop, pcs};
  endfunction

  function automatic logic [18:0] outs();
    return {PC_write, PC_write_cond, IorD, mem_read, mem_write, IR_write, MDR_write,
            reg_dst, mem_to_reg, reg_write, ALU_srcA, ALU_srcB, ALU_op, PC_src};
  endfunction

  // Instruction-level model: cycle count and the control word expected in cycle k
  function automatic int model_len(input logic [5:0] op, input logic j);
    case (op)
      6'b100011: return 5;
      6'b101011: return 4;
      6'b000000: return j ? 3 : 4;
      6'b001000, 6'b001010: return 4;
      6'b000100, 6'b000010, 6'b000011: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic [18:0] model(input logic [5:0] op, input logic j, input int k);
    if (k == 0) return mk(1,0,0,1,0,1,0, 2'd0,2'd0,0,0, 2'd1,2'd0,2'd0);
    if (k == 1) return mk(0,0,0,0,0,0,0, 2'd0,2'd0,0,0, 2'd3,2'd0,2'd0);
    case (op)
      6'b000000:
        if (k == 2) return j ? mk(1,0,0,0,0,0,0, 2'd0,2'd0,0,1, 2'd0,2'd2,2'd3)
                             : mk(0,0,0,0,0,0,0, 2'd0,2'd0,0,1, 2'd0,2'd2,2'd0);
        else if (k == 3 && !j) return mk(0,0,0,0,0,0,0, 2'd1,2'd0,1,0, 2'd0,2'd0,2'd0);
      6'b100011, 6'b101011:
        if (k == 2) return mk(0,0,0,0,0,0,0, 2'd0,2'd0,0,1, 2'd2,2'd0,2'd0);
        else if (k == 3 && op[3]) return mk(0,0,1,0,1,0,0, 2'd0,2'd0,0,0, 2'd0,2'd0,2'd0);
        else if (k == 3) return mk(0,0,1,1,0,0,1, 2'd0,2'd0,0,0, 2'd0,2'd0,2'd0);
        else if (k == 4 && !op[3]) return mk(0,0,0,0,0,0,0, 2'd0,2'd1,1,0, 2'd0,2'd0,2'd0);
      6'b000100: if (k == 2) return mk(0,1,0,0,0,0,0, 2'd0,2'd0,0,1, 2'd0,2'd1,2'd1);
      6'b000010: if (k == 2) return mk(1,0,0,0,0,0,0, 2'd0,2'd0,0,0, 2'd0,2'd0,2'd2);
      6'b000011: if (k == 2) return mk(1,0,0,0,0,0,0, 2'd2,2'd2,1,0, 2'd0,2'd0,2'd2);
      6'b001000, 6'b001010:
        if (k == 2) return mk(0,0,0,0,0,0,0, 2'd0,2'd0,0,1, 2'd2, (op == 6'b001010) ? 2'd3 : 2'd0, 2'd0);
        else if (k == 3) return mk(0,0,0,0,0,0,0, 2'd0,2'd0,1,0, 2'd0,2'd0,2'd0);
      default: ;
    endcase
    return '0;
  endfunction

  task automatic check(input string name, input logic [18:0] got, input logic [18:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  // Entered at the negedge of a FETCH cycle; returns at the negedge of the next FETCH
  task automatic run_instr(input logic [5:0] op, input logic j, input logic z, input int exp_len,
                           input string name);
    int lat = 99;
    opcode = op; jr = j; zero = z;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) begin
        @(negedge clk);
        if (IR_write === 1'b1) begin lat = k; break; end
      end
      check($sformatf("%s_cyc%0d", name, k), outs(), model(op, j, k));
    end
    n_vec++;
    if (lat != exp_len) begin
      n_err++;
      $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_len);
    end
  endtask

  typedef struct {
    logic [5:0] op;
    logic       j;
    logic       z;
    int         len;
    string      name;
  } vec_t;

  vec_t tbl[11];
  logic [5:0] legal[8];

  initial begin
    tbl[0]  = '{6'b100011, 1'b0, 1'b0, 5, "lw"};
    tbl[1]  = '{6'b101011, 1'b0, 1'b1, 4, "sw"};
    tbl[2]  = '{6'b000000, 1'b0, 1'b0, 4, "rtype"};
    tbl[3]  = '{6'b000000, 1'b1, 1'b0, 3, "jr"};
    tbl[4]  = '{6'b000100, 1'b0, 1'b1, 3, "beq_z1"};
    tbl[5]  = '{6'b000100, 1'b0, 1'b0, 3, "beq_z0"};
    tbl[6]  = '{6'b000010, 1'b0, 1'b0, 3, "j"};
    tbl[7]  = '{6'b000011, 1'b1, 1'b0, 3, "jal"};
    tbl[8]  = '{6'b001000, 1'b0, 1'b0, 4, "addi"};
    tbl[9]  = '{6'b001010, 1'b0, 1'b0, 4, "slti"};
    tbl[10] = '{6'b111111, 1'b1, 1'b1, 2, "invalid"};
    legal = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
              6'b000010, 6'b000011, 6'b001000, 6'b001010};

    rst = 1'b1; opcode = 6'b0; zero = 1'b0; jr = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("reset_quiet", outs(), '0);
    end
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) run_instr(tbl[i].op, tbl[i].j, tbl[i].z, tbl[i].len, tbl[i].name);

    // reset in the middle of lw's address phase
    opcode = 6'b100011; jr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("lw_mem_addr", outs(), model(6'b100011, 1'b0, 2));
    #2 rst = 1'b1;
    #1 check("midreset_async", outs(), '0);
    repeat (2) begin
      @(negedge clk);
      check("midreset_held", outs(), '0);
    end
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    run_instr(6'b101011, 1'b0, 1'b0, 4, "post_reset_sw");

    for (int n = 0; n < 150; n++) begin
      logic [5:0] op;
      logic j;
      if ($urandom_range(0, 9) < 7) op = legal[$urandom_range(0, 7)];
      else op = 6'($urandom);
      j = 1'($urandom);
      run_instr(op, j, 1'($urandom), model_len(op, j), $sformatf("rnd%0d_op%b", n, op));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
